seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing scan controller for the 4-digit common-anode 7-segment display. It holds a 16-bit display value in a tear-free shadow register and cycles one digit slot at a time. For each slot it drives the 2-bit digit select, the active-low anode vector and the 4-bit nibble that the downstream hex-to-segment decoder converts to `DISPLAY[6:0]`. Blank dead time at the start of each slot suppresses ghosting, and optional leading-zero blanking is provided.

## Interface
- `PRESCALE`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK`, default 2000: dead-time cycles at the start of each slot with all anodes off; must satisfy 0 ≤ `BLANK` < `PRESCALE`.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 16: display value; nibble k is shown on digit k, digit 0 rightmost.
- `load` in 1: single-cycle strobe that captures `value` and `lz_en`.
- `lz_en` in 1: leading-zero blanking enable, captured with `load`.
- `sel` out 2: current digit index, feeding the decoder's select input.
- `nibble` out 4: `shadow[4*sel +: 4]`, feeding the segment decoder.
- `AN` out 4: anode enables, active-low, one-hot-low or all-ones.
- `busy` out 1: high while a loaded value waits for the frame boundary.
- `frame` out 1: one-cycle pulse when a new shadow value becomes visible.

## Operation
- Slot counter `cnt` counts 0..`PRESCALE`-1 and wraps to 0. At the wrap, `sel` increments modulo 4 (3→0).
- Frame boundary: the cycle with `cnt`=`PRESCALE`-1 and `sel`=3. Frame period is 4·`PRESCALE` cycles.
- Load path:
  - `load`=1 writes `value` and `lz_en` into the pending register and sets `busy`.
  - A later `load` in the same frame overwrites pending; the last one wins.
- Boundary update: if `busy`=1, `shadow`←pending and `lz`←pending `lz_en`, and `busy` clears.
- Simultaneous `load` and boundary:
  - The old pending value transfers to shadow.
  - The new value is captured into pending, and `busy` stays 1.
  - If `busy` was 0, only the capture happens, and the transfer occurs at the next boundary.
- `AN` rule:
  - All ones while `cnt` < `BLANK`, or while the current digit is LZ-blanked.
  - Otherwise `AN` = ~(4'b0001 << `sel`).
- LZ-blank: with `lz`=1, digit k (k = 1..3) is blanked when nibbles 3..k of shadow are all zero. Digit 0 is never blanked.
- `sel`, `nibble` and `AN` are derived from registers only (`cnt`, `sel`, `shadow`, `lz`). No input reaches them combinationally.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - `cnt`=0, `sel`=0, `shadow`=0, pending=0, `lz`=0, `busy`=0, `frame`=0, `nibble`=0.
  - `AN`=4'b1111, or 4'b1110 if `BLANK`=0.
- Deassertion of `rst_n` is synchronised externally. The first rising edge after release advances `cnt` to 1.
- `load` on edge t: `busy`=1 after edge t.
- Transfer to shadow occurs on the edge that ends the boundary cycle. On that same edge `sel`→0, `cnt`→0 and `frame` rises for exactly one cycle.
- Worst-case `load`-to-display latency: 4·`PRESCALE` + 1 cycles.
- Digit k with `AN` low: `cnt` in [`BLANK`, `PRESCALE`-1], i.e. `PRESCALE`-`BLANK` cycles per slot.
- Reset asserted mid-frame discards pending and shadow data, and scanning restarts at slot 0.

## Test plan
Bench parameters: `PRESCALE`=8, `BLANK`=2.
- **Reset:** hold `rst_n`=0 → `AN`=1111, `sel`=0, `nibble`=0, `busy`=0, `frame`=0. After release, `AN`=1110 once `cnt`=2, and `sel`=1 after 8 edges.
- **Load and display:** pulse `load` with `value`=16'hA5C3, `lz_en`=0, in slot 1 → `busy`=1 until the boundary. Then `frame` pulses for one cycle and `busy`=0. The next frame shows nibble/`AN` = 3/1110, C/1101, 5/1011, A/0111, each with `AN`=1111 for the first 2 cycles of its slot.
- **Leading-zero blanking:** load 16'h0070 with `lz_en`=1 → digits 0 and 1 light (0, 7), and digits 2 and 3 keep `AN`=1111 for the whole slot. Load 16'h0000 with `lz_en`=1 → only digit 0 lights, showing 0.
- **Load at boundary:** load 16'h1111, then load 16'h2222 exactly in the boundary cycle → the next frame shows 1111, `busy` stays 1, and the frame after shows 2222 with `frame` pulsing both times.
- **Last load wins:** load 16'h1234 then 16'h5678 within one frame → only 5678 is ever displayed, with a single `frame` pulse.
- **Async reset mid-frame:** pull `rst_n` low in slot 2 with `busy`=1 and no clock edge → outputs take reset values immediately. After release, the display shows 0000 and `busy`=0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a tear-free shadow
// register, per-slot anode dead time and optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned BLANK    = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lz_en,
    output logic [1:0]  sel,
    output logic [3:0]  nibble,
    output logic [3:0]  AN,
    output logic        busy,
    output logic        frame
);

    localparam int unsigned      CNT_W   = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [3:0]       AN_RST  = (BLANK == 0) ? 4'b1110 : 4'b1111;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [15:0]      r_shadow;
    logic             r_lz;
    logic [15:0]      r_pend;
    logic             r_pend_lz;
    logic             r_busy;
    logic             r_frame;
    logic [3:0]       r_nibble;
    logic [3:0]       r_an;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_wrap;
    logic             w_boundary;
    logic             w_in_blank;
    logic [15:0]      w_shadow_nxt;
    logic             w_lz_nxt;
    logic [15:0]      w_pend_nxt;
    logic             w_pend_lz_nxt;
    logic             w_busy_nxt;
    logic             w_frame_nxt;
    logic [3:0]       w_nibble_nxt;
    logic [3:0]       w_an_nxt;

    function automatic logic [3:0] nib_of(input logic [15:0] s, input logic [1:0] k);
        logic [3:0] n;
        case (k)
            2'd0:    n = s[3:0];
            2'd1:    n = s[7:4];
            2'd2:    n = s[11:8];
            default: n = s[15:12];
        endcase
        return n;
    endfunction

    // Digit k is dark when it and every more-significant nibble are zero.
    function automatic logic lz_dark(input logic [15:0] s, input logic lz, input logic [1:0] k);
        logic d;
        case (k)
            2'd1:    d = lz && (s[15:4] == 12'h000);
            2'd2:    d = lz && (s[15:8] == 8'h00);
            2'd3:    d = lz && (s[15:12] == 4'h0);
            default: d = 1'b0;
        endcase
        return d;
    endfunction

    assign w_wrap     = (r_cnt == CNT_MAX);
    assign w_boundary = w_wrap && (r_sel == 2'd3);
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_sel_nxt  = w_wrap ? r_sel + 2'd1 : r_sel;

    // Dead time at the start of every slot; absent entirely when BLANK is 0.
    if (BLANK == 0) begin : g_no_blank
        assign w_in_blank = 1'b0;
    end else begin : g_blank
        assign w_in_blank = (w_cnt_nxt < CNT_W'(BLANK));
    end

    always_comb begin
        w_shadow_nxt  = r_shadow;
        w_lz_nxt      = r_lz;
        w_pend_nxt    = r_pend;
        w_pend_lz_nxt = r_pend_lz;
        w_busy_nxt    = r_busy;
        w_frame_nxt   = 1'b0;

        if (w_boundary && r_busy) begin
            w_shadow_nxt = r_pend;
            w_lz_nxt     = r_pend_lz;
            w_busy_nxt   = 1'b0;
            w_frame_nxt  = 1'b1;
        end
        // A load in the boundary cycle still lands in pending after the transfer.
        if (load) begin
            w_pend_nxt    = value;
            w_pend_lz_nxt = lz_en;
            w_busy_nxt    = 1'b1;
        end

        w_nibble_nxt = nib_of(w_shadow_nxt, w_sel_nxt);
        if (w_in_blank || lz_dark(w_shadow_nxt, w_lz_nxt, w_sel_nxt)) begin
            w_an_nxt = 4'b1111;
        end else begin
            w_an_nxt = ~(4'b0001 << w_sel_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_sel     <= 2'd0;
            r_shadow  <= 16'h0000;
            r_lz      <= 1'b0;
            r_pend    <= 16'h0000;
            r_pend_lz <= 1'b0;
            r_busy    <= 1'b0;
            r_frame   <= 1'b0;
            r_nibble  <= 4'h0;
            r_an      <= AN_RST;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_shadow  <= w_shadow_nxt;
            r_lz      <= w_lz_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_lz <= w_pend_lz_nxt;
            r_busy    <= w_busy_nxt;
            r_frame   <= w_frame_nxt;
            r_nibble  <= w_nibble_nxt;
            r_an      <= w_an_nxt;
        end
    end

    assign sel    = r_sel;
    assign nibble = r_nibble;
    assign AN     = r_an;
    assign busy   = r_busy;
    assign frame  = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: loads queue the frame they should
// appear in, and a per-cycle monitor checks the scanned output against them.
module tb_seg7_scan_ctrl;

    localparam int unsigned PRESCALE = 8;
    localparam int unsigned BLANK    = 2;
    localparam int unsigned FRAME    = 4 * PRESCALE;

    typedef struct packed {
        logic [15:0] v;
        logic        lz;
        logic [31:0] tgt;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [1:0]  sel;
    logic [3:0]  nibble;
    logic [3:0]  AN;
    logic        busy;
    logic        frame;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    sb_entry_t   sb[$];
    logic [15:0] disp    = 16'h0000;
    logic        disp_lz = 1'b0;

    seg7_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .load   (load),
        .lz_en  (lz_en),
        .sel    (sel),
        .nibble (nibble),
        .AN     (AN),
        .busy   (busy),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    // Edges since reset release; slot counter and digit follow from this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int unsigned c;
        int unsigned cnt_m;
        int unsigned sel_m;
        logic        frame_m;
        logic [15:0] upper;
        logic [3:0]  an_m;
        if (rst_n) begin
            c       = cyc;
            cnt_m   = c % PRESCALE;
            sel_m   = (c / PRESCALE) % 4;
            frame_m = 1'b0;
            if (c > 0 && (c % FRAME) == 0 && sb.size() > 0 && sb[0].tgt == (c / FRAME) - 1) begin
                disp    = sb[0].v;
                disp_lz = sb[0].lz;
                void'(sb.pop_front());
                frame_m = 1'b1;
            end
            upper = disp >> (4 * sel_m);
            if (cnt_m < BLANK || (disp_lz && sel_m != 0 && upper == 16'h0000))
                an_m = 4'b1111;
            else
                an_m = 4'b1111 ^ (4'b0001 << sel_m);
            check("frame",  32'(frame),  32'(frame_m));
            check("busy",   32'(busy),   (sb.size() > 0) ? 32'd1 : 32'd0);
            check("sel",    32'(sel),    sel_m);
            check("nibble", 32'(nibble), 32'(upper[3:0]));
            check("an",     32'(AN),     32'(an_m));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called 2 time units after a rising edge; waits for the given frame phase.
    task automatic wait_phase(input int unsigned m);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((cyc % FRAME) == m) return;
            @(posedge clk);
            #2;
        end
        check("wait_phase_timeout", cyc % FRAME, m);
    endtask

    task automatic do_load(input logic [15:0] v, input logic lz);
        int unsigned t;
        sb_entry_t   e;
        t      = (cyc + 1) / FRAME;
        value  = v;
        lz_en  = lz;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load   = 1'b0;
        e.v    = v;
        e.lz   = lz;
        e.tgt  = t;
        if (sb.size() > 0 && sb[sb.size() - 1].tgt == t) sb[sb.size() - 1] = e;
        else sb.push_back(e);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},     32'(AN),     32'h0000000F);
        check({tag, "_sel"},    32'(sel),    32'd0);
        check({tag, "_nibble"}, 32'(nibble), 32'd0);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_frame"},  32'(frame),  32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        wait_phase(9);
        do_load(16'hA5C3, 1'b0);
        idle(70);

        do_load(16'h0070, 1'b1);
        idle(70);
        do_load(16'h0000, 1'b1);
        idle(70);

        wait_phase(5);
        do_load(16'h1111, 1'b0);
        wait_phase(FRAME - 1);
        do_load(16'h2222, 1'b0);
        idle(80);

        wait_phase(3);
        do_load(16'h1234, 1'b0);
        wait_phase(20);
        do_load(16'h5678, 1'b0);
        idle(80);

        wait_phase(17);
        do_load(16'hABCD, 1'b0);
        check("busy_before_reset", 32'(busy), 32'd1);
        #4;
        rst_n = 1'b0;
        sb.delete();
        disp    = 16'h0000;
        disp_lz = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #2;
        rst_n = 1'b1;
        idle(80);

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
